// File: rtl/tblink_rpc_endpoint.sv
// TbLink RPC network endpoint: routes the 8-bit network stream to the local port or onward,
// and merges local packets onto the network output under packet-level round-robin arbitration.
module tblink_rpc_endpoint #(
  parameter logic [7:0] ADDR = 8'h01
) (
  input  logic       uclock,
  input  logic       reset,
  input  logic       hreq_i,
  output logic       hreq_o,
  input  logic [7:0] neti_dat,
  input  logic       neti_valid,
  output logic       neti_ready,
  output logic [7:0] neto_dat,
  output logic       neto_valid,
  input  logic       neto_ready,
  output logic [7:0] tipo_dat,
  output logic       tipo_valid,
  input  logic       tipo_ready,
  input  logic [7:0] tipi_dat,
  input  logic       tipi_valid,
  output logic       tipi_ready
);
  typedef enum logic [1:0] {HDR, LEN, BODY} pst_t;

  pst_t       r_ni_st, w_ni_nxt, r_ti_st, w_ti_nxt;
  logic [7:0] r_ni_cnt, r_ti_cnt;
  logic       r_ni_local, r_run, r_lock, r_gnt_sel, r_prio;
  logic       r_neto_vld, r_neto_last, r_neto_src, r_tipo_vld, r_tipo_last;
  logic [7:0] r_neto_dat, r_tipo_dat;
  logic       r_tb_busy, r_ib_busy;

  logic       w_ni_xfer, w_ti_xfer, w_ni_last, w_ti_last, w_ni_local;
  logic       w_req_n, w_req_t, w_sel, w_tipo_free, w_neto_free;
  logic       w_tipo_ld, w_neto_ld, w_neto_in_last, w_ti_open;
  logic [7:0] w_neto_in_dat;

  // Parser state registers and BODY down-counters
  always_ff @(posedge uclock) begin
    if (reset) begin
      r_ni_st    <= HDR;
      r_ti_st    <= HDR;
      r_ni_cnt   <= '0;
      r_ti_cnt   <= '0;
      r_ni_local <= 1'b0;
    end else begin
      r_ni_st <= w_ni_nxt;
      r_ti_st <= w_ti_nxt;
      if (w_ni_xfer) begin
        if (r_ni_st == HDR) r_ni_local <= w_ni_local;
        if (r_ni_st == LEN) r_ni_cnt <= neti_dat;
        else if (r_ni_st == BODY) r_ni_cnt <= r_ni_cnt - 8'd1;
      end
      if (w_ti_xfer) begin
        if (r_ti_st == LEN) r_ti_cnt <= tipi_dat;
        else if (r_ti_st == BODY) r_ti_cnt <= r_ti_cnt - 8'd1;
      end
    end
  end

  always_comb begin
    w_ni_nxt = r_ni_st;
    w_ti_nxt = r_ti_st;
    if (w_ni_xfer)
      case (r_ni_st)
        HDR:     w_ni_nxt = LEN;
        LEN:     w_ni_nxt = (neti_dat == 8'd0) ? HDR : BODY;
        BODY:    w_ni_nxt = (r_ni_cnt == 8'd1) ? HDR : BODY;
        default: w_ni_nxt = HDR;
      endcase
    if (w_ti_xfer)
      case (r_ti_st)
        HDR:     w_ti_nxt = LEN;
        LEN:     w_ti_nxt = (tipi_dat == 8'd0) ? HDR : BODY;
        BODY:    w_ti_nxt = (r_ti_cnt == 8'd1) ? HDR : BODY;
        default: w_ti_nxt = HDR;
      endcase
  end

  always_comb begin
    w_ni_last = (r_ni_st == LEN && neti_dat == 8'd0) || (r_ni_st == BODY && r_ni_cnt == 8'd1);
    w_ti_last = (r_ti_st == LEN && tipi_dat == 8'd0) || (r_ti_st == BODY && r_ti_cnt == 8'd1);
  end

  // Routing is decided on byte0 and then held; hreq_i only stops tipi at a packet boundary
  assign w_ni_local  = (r_ni_st == HDR) ? (neti_dat == ADDR) : r_ni_local;
  assign w_ti_open   = (r_ti_st != HDR) || !hreq_i;
  assign w_req_n     = neti_valid && !w_ni_local;
  assign w_req_t     = tipi_valid && w_ti_open;
  assign w_sel       = r_lock ? r_gnt_sel : ((w_req_n && w_req_t) ? r_prio : w_req_t);
  assign w_tipo_free = !r_tipo_vld || tipo_ready;
  assign w_neto_free = !r_neto_vld || neto_ready;

  assign neti_ready  = r_run && (w_ni_local ? w_tipo_free : (w_neto_free && !w_sel));
  assign tipi_ready  = r_run && w_neto_free && w_sel && w_ti_open;
  assign w_ni_xfer   = neti_valid && neti_ready;
  assign w_ti_xfer   = tipi_valid && tipi_ready;

  assign w_tipo_ld      = w_ni_xfer && w_ni_local;
  assign w_neto_ld      = (w_ni_xfer && !w_ni_local) || w_ti_xfer;
  assign w_neto_in_dat  = w_sel ? tipi_dat : neti_dat;
  assign w_neto_in_last = w_sel ? w_ti_last : w_ni_last;

  // An unlocked load is always a byte0, since a locked owner holds the grant to its last byte
  always_ff @(posedge uclock) begin
    if (reset) begin
      r_run     <= 1'b0;
      r_lock    <= 1'b0;
      r_gnt_sel <= 1'b0;
      r_prio    <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_neto_ld) begin
        if (!r_lock) begin
          r_lock    <= 1'b1;
          r_gnt_sel <= w_sel;
          if (w_req_n && w_req_t) r_prio <= !w_sel;
        end else if (w_neto_in_last) begin
          r_lock <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge uclock) begin
    if (reset) begin
      r_neto_vld  <= 1'b0;
      r_neto_dat  <= '0;
      r_neto_last <= 1'b0;
      r_neto_src  <= 1'b0;
      r_tipo_vld  <= 1'b0;
      r_tipo_dat  <= '0;
      r_tipo_last <= 1'b0;
    end else begin
      if (w_neto_ld) begin
        r_neto_vld  <= 1'b1;
        r_neto_dat  <= w_neto_in_dat;
        r_neto_last <= w_neto_in_last;
        r_neto_src  <= w_sel;
      end else if (neto_ready) begin
        r_neto_vld <= 1'b0;
      end
      if (w_tipo_ld) begin
        r_tipo_vld  <= 1'b1;
        r_tipo_dat  <= neti_dat;
        r_tipo_last <= w_ni_last;
      end else if (tipo_ready) begin
        r_tipo_vld <= 1'b0;
      end
    end
  end

  // Local traffic tracking: set on byte0 accept, cleared when the last byte leaves
  always_ff @(posedge uclock) begin
    if (reset) begin
      r_tb_busy <= 1'b0;
      r_ib_busy <= 1'b0;
    end else begin
      if (w_tipo_ld && r_ni_st == HDR) r_tb_busy <= 1'b1;
      else if (r_tipo_vld && tipo_ready && r_tipo_last) r_tb_busy <= 1'b0;
      if (w_ti_xfer && r_ti_st == HDR) r_ib_busy <= 1'b1;
      else if (r_neto_vld && neto_ready && r_neto_last && r_neto_src) r_ib_busy <= 1'b0;
    end
  end

  assign hreq_o     = r_tb_busy || r_ib_busy;
  assign neto_valid = r_neto_vld;
  assign neto_dat   = r_neto_dat;
  assign tipo_valid = r_tipo_vld;
  assign tipo_dat   = r_tipo_dat;
endmodule

// File: tb/tb_tblink_rpc_endpoint.sv
// Directed bench for tblink_rpc_endpoint (ADDR=0x01): routing, arbitration, stalls, hreq, reset.
module tb_tblink_rpc_endpoint;
  logic       uclock = 1'b0;
  logic       reset = 1'b1;
  logic       hreq_i = 1'b0;
  logic       hreq_o;
  logic [7:0] neti_dat = 8'h00;
  logic       neti_valid = 1'b0;
  logic       neti_ready;
  logic [7:0] neto_dat;
  logic       neto_valid;
  logic       neto_ready = 1'b0;
  logic [7:0] tipo_dat;
  logic       tipo_valid;
  logic       tipo_ready = 1'b0;
  logic [7:0] tipi_dat = 8'h00;
  logic       tipi_valid = 1'b0;
  logic       tipi_ready;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] q_neto[$];
  logic [7:0] q_tipo[$];
  logic [7:0] exp_q[$];
  logic       hreq_seen = 1'b0;
  logic [7:0] pn[8];
  logic [7:0] pt[8];

  tblink_rpc_endpoint #(.ADDR(8'h01)) dut (
    .uclock(uclock), .reset(reset), .hreq_i(hreq_i), .hreq_o(hreq_o),
    .neti_dat(neti_dat), .neti_valid(neti_valid), .neti_ready(neti_ready),
    .neto_dat(neto_dat), .neto_valid(neto_valid), .neto_ready(neto_ready),
    .tipo_dat(tipo_dat), .tipo_valid(tipo_valid), .tipo_ready(tipo_ready),
    .tipi_dat(tipi_dat), .tipi_valid(tipi_valid), .tipi_ready(tipi_ready)
  );

  always #5 uclock = ~uclock;

  // Output transfers are sampled mid-cycle; stimulus changes 2 units after the rising edge
  always @(negedge uclock) begin
    if (neto_valid && neto_ready) q_neto.push_back(neto_dat);
    if (tipo_valid && tipo_ready) q_tipo.push_back(tipo_dat);
    if (hreq_o) hreq_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input bit sel_tipo);
    int n;
    n = sel_tipo ? q_tipo.size() : q_neto.size();
    chk({tag, "_len"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      chk($sformatf("%s[%0d]", tag, i), sel_tipo ? q_tipo[i] : q_neto[i], exp_q[i]);
  endtask

  task automatic clr();
    q_neto.delete();
    q_tipo.delete();
    hreq_seen = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge uclock);
    #2;
  endtask

  task automatic neti_send(input logic [7:0] b);
    int n;
    n = 0;
    neti_dat = b;
    neti_valid = 1'b1;
    @(negedge uclock);
    while (!neti_ready && n < 50) begin n++; @(negedge uclock); end
    if (n >= 50) chk("neti_ready_timeout", n, 0);
    @(posedge uclock);
    #2;
    neti_valid = 1'b0;
  endtask

  task automatic tipi_send(input logic [7:0] b);
    int n;
    n = 0;
    tipi_dat = b;
    tipi_valid = 1'b1;
    @(negedge uclock);
    while (!tipi_ready && n < 50) begin n++; @(negedge uclock); end
    if (n >= 50) chk("tipi_ready_timeout", n, 0);
    @(posedge uclock);
    #2;
    tipi_valid = 1'b0;
  endtask

  task automatic neti_pkt(input int len);
    for (int i = 0; i < len; i++) neti_send(pn[i]);
  endtask

  task automatic tipi_pkt(input int len);
    for (int i = 0; i < len; i++) tipi_send(pt[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge uclock);
    @(negedge uclock);
    chk("rst_neto_valid", neto_valid, 0);
    chk("rst_tipo_valid", tipo_valid, 0);
    chk("rst_neti_ready", neti_ready, 0);
    chk("rst_tipi_ready", tipi_ready, 0);
    chk("rst_hreq_o", hreq_o, 0);
    @(posedge uclock); #2;
    reset = 1'b0;
    neto_ready = 1'b1;
    tipo_ready = 1'b1;

    // Local delivery with 1-cycle latency
    clr();
    neti_send(8'h01);
    #1;
    chk("t1_lat_valid", tipo_valid, 1);
    chk("t1_lat_dat", tipo_dat, 8'h01);
    chk("t1_hreq_hi", hreq_o, 1);
    neti_send(8'h02);
    neti_send(8'hAA);
    neti_send(8'hBB);
    idle(3);
    exp_q = {8'h01, 8'h02, 8'hAA, 8'hBB};
    chk_q("t1_tipo", 1'b1);
    chk("t1_neto_idle", q_neto.size(), 0);
    chk("t1_hreq_lo", hreq_o, 0);

    // Pass-through
    clr();
    pn = '{8'h05, 8'h01, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    neti_pkt(3);
    idle(3);
    exp_q = {8'h05, 8'h01, 8'h3C};
    chk_q("t2_neto", 1'b0);
    chk("t2_tipo_idle", q_tipo.size(), 0);
    chk("t2_hreq_seen", hreq_seen, 0);

    // Local send, zero-length packet
    clr();
    pt = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tipi_pkt(2);
    idle(3);
    exp_q = {8'h07, 8'h00};
    chk_q("t3_neto", 1'b0);
    chk("t3_hreq_seen", hreq_seen, 1);
    chk("t3_hreq_lo", hreq_o, 0);

    // Contention right after reset: neti first, then round-robin puts tipi first
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    clr();
    pn = '{8'h09, 8'h02, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00};
    pt = '{8'h0A, 8'h01, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    fork
      neti_pkt(4);
      tipi_pkt(3);
    join
    idle(3);
    exp_q = {8'h09, 8'h02, 8'h11, 8'h22, 8'h0A, 8'h01, 8'h33};
    chk_q("t4a_neto", 1'b0);
    clr();
    fork
      neti_pkt(4);
      tipi_pkt(3);
    join
    idle(3);
    exp_q = {8'h0A, 8'h01, 8'h33, 8'h09, 8'h02, 8'h11, 8'h22};
    chk_q("t4b_neto", 1'b0);

    // Back-pressure on tipo
    clr();
    neti_send(8'h01);
    tipo_ready = 1'b0;
    neti_dat = 8'h03;
    neti_valid = 1'b1;
    repeat (5) begin
      @(negedge uclock);
      chk("t5_stall_valid", tipo_valid, 1);
      chk("t5_stall_dat", tipo_dat, 8'h01);
      chk("t5_stall_neti_ready", neti_ready, 0);
    end
    @(posedge uclock); #2;
    tipo_ready = 1'b1;
    neti_send(8'h03);
    neti_send(8'hA1);
    neti_send(8'hA2);
    neti_send(8'hA3);
    idle(3);
    exp_q = {8'h01, 8'h03, 8'hA1, 8'hA2, 8'hA3};
    chk_q("t5_tipo", 1'b1);

    // hreq_i blocks a new local packet
    hreq_i = 1'b1;
    tipi_dat = 8'h0B;
    tipi_valid = 1'b1;
    repeat (4) begin
      @(negedge uclock);
      chk("t6_hreq_block", tipi_ready, 0);
    end
    @(posedge uclock); #2;
    tipi_valid = 1'b0;
    hreq_i = 1'b0;

    // Reset in the middle of a local packet
    neti_send(8'h01);
    neti_send(8'h05);
    neti_send(8'hC1);
    reset = 1'b1;
    @(posedge uclock);
    @(negedge uclock);
    chk("t6_rst_neto_valid", neto_valid, 0);
    chk("t6_rst_tipo_valid", tipo_valid, 0);
    chk("t6_rst_neti_ready", neti_ready, 0);
    chk("t6_rst_tipi_ready", tipi_ready, 0);
    chk("t6_rst_hreq_o", hreq_o, 0);
    @(posedge uclock); #2;
    reset = 1'b0;
    clr();
    pn = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    neti_pkt(2);
    pn = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    neti_pkt(2);
    idle(3);
    exp_q = {8'h05, 8'h00};
    chk_q("t6_neto", 1'b0);
    exp_q = {8'h01, 8'h00};
    chk_q("t6_tipo", 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/tblink_rpc_endpoint.md
# tblink_rpc_endpoint

Byte-stream network endpoint for the TbLink RPC gateway fabric. It sits on a chained 8-bit ready/valid network: packets arriving on the network input are either delivered to the local target interface port (when addressed to this endpoint) or forwarded to the network output. Packets produced by the local port are merged onto the network output with packet-level arbitration. It also drives a halt-request flag while local traffic is in flight.

## Interface
Parameters:
- ADDR, 1, 8-bit network address of this endpoint (0x00–0xFE).

Ports (ready/valid groups are `<prefix>_dat[7:0]`, `<prefix>_valid`, `<prefix>_ready`):
- uclock  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- hreq_i  in  1  halt request from upstream/system; blocks new local packets.
- hreq_o  out  1  halt request from this endpoint; high while local traffic is in flight.
- neti_dat/valid/ready  in/in/out  8/1/1  network input stream.
- neto_dat/valid/ready  out/out/in  8/1/1  network output stream.
- tipo_dat/valid/ready  out/out/in  8/1/1  packets delivered to the local port.
- tipi_dat/valid/ready  in/in/out  8/1/1  packets sent by the local port.

## Operation
- Packet format: byte0 = destination address, byte1 = payload length N (0–255), then N payload bytes; N+2 bytes total. All bytes, including header, are passed through unchanged.
- A transfer occurs on a cycle with valid && ready both high.
- neti parser, states: HDR → LEN → BODY → HDR. LEN → HDR directly when N = 0. A BODY down-counter is loaded with N and returns to HDR after the last byte.
- Routing is decided on the byte0 transfer and held for the whole packet:
  - dat == ADDR → tipo.
  - otherwise → pass-through to neto.
- tipi parser uses the same HDR/LEN/BODY scheme. Its destination is not checked. A local packet addressed to ADDR still goes to neto.
- neto arbiter: packet-granular, two requesters (neti pass-through, tipi).
  - A grant is locked from the byte0 transfer until the final byte transfers. Bytes of two packets never interleave.
  - When both request in the same cycle at a packet boundary, round-robin applies. Priority after reset is neti.
  - The non-granted source sees ready = 0.
- hreq_i: when high at a tipi packet boundary (tipi parser in HDR), tipi_ready = 0. A tipi packet already in progress completes normally.
- hreq_o is high from the cycle after byte0 of a packet is accepted into tipo or from tipi. It stays high until the cycle after the last byte of all such in-flight local packets leaves the endpoint; otherwise it is 0.

## Timing
- Each output (neto, tipo) has a single-entry output register.
- Source ready = (output register empty) OR (output register draining this cycle), gated by routing and grant.
- Latency: a byte accepted at edge k is valid on the output from edge k. It is visible in the cycle after the accept, i.e. 1-cycle latency.
- Full throughput: 1 byte/cycle per path when downstream ready stays high.
- Back-pressure: with downstream ready low, at most one byte is buffered and the input ready drops. No byte is lost or duplicated.
- neti-to-tipo and tipi-to-neto traffic may flow concurrently.
- Reset (synchronous, any time including mid-packet):
  - All valids, all readys and hreq_o are 0 in the cycle after reset is sampled high.
  - Parsers return to HDR, output registers are emptied, arbiter priority returns to neti.
  - Partial packets are discarded.
  - Readys may rise in the first cycle after reset deasserts.
- Outputs hold dat stable while valid is high and ready is low.

## Test plan
- ADDR=1, neti sends 01 02 AA BB → tipo emits 01 02 AA BB, 1-cycle latency, neto stays idle; hreq_o high during delivery, then 0.
- neti sends 05 01 3C → neto emits 05 01 3C unchanged; tipo never valid; hreq_o stays 0.
- tipi sends 07 00 → neto emits 07 00; the N = 0 packet ends after 2 bytes; hreq_o pulses.
- neti pass-through 09 02 11 22 and tipi 0A 01 33 start in the same cycle after reset → neto emits 09 02 11 22 0A 01 33 with no interleaving. Repeating this gives tipi first (round-robin).
- Hold tipo_ready low 5 cycles during a 01 03 A1 A2 A3 delivery → neti_ready drops with one byte held; tipo later emits all bytes in order, with dat stable while stalled.
- Assert hreq_i before a tipi packet → tipi_ready stays 0. Assert reset mid-packet → all outputs 0 next cycle, and a fresh packet afterwards routes correctly.
